// File: rtl/data_mem_be_if.sv
// Request/response bundle between the MEM stage and the byte-enabled data memory.
interface data_mem_be_if #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 32
);
  localparam int OFFW = $clog2(DWIDTH / 8);

  logic                   req;
  logic                   we;
  logic [1:0]             size;
  logic                   sext;
  logic [AWIDTH+OFFW-1:0] address;
  logic [DWIDTH-1:0]      data_in;
  logic                   ready;
  logic [DWIDTH-1:0]      data_out;
  logic                   rvalid;
  logic                   misalign;

  modport master (
    output req, we, size, sext, address, data_in,
    input  ready, data_out, rvalid, misalign
  );

  modport slave (
    input  req, we, size, sext, address, data_in,
    output ready, data_out, rvalid, misalign
  );
endinterface

// File: rtl/data_mem_be.sv
// Byte-addressed data memory: B/H/W/D accesses with lane merge on stores,
// sign/zero-extended registered loads, misalignment flagging and a
// one-word-per-cycle clear sweep after reset.
module data_mem_be #(
  parameter int AWIDTH     = 10,
  parameter int DWIDTH     = 32,
  parameter bit INIT_CLEAR = 1'b1
) (
  input logic          clk,
  input logic          clr_n,
  data_mem_be_if.slave bus
);
  localparam int LANES = DWIDTH / 8;
  localparam int OFFW  = $clog2(LANES);
  localparam int DEPTH = 2 ** AWIDTH;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] ptr_q, ptr_d;
  logic              clr_we;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] data_out_q;
  logic              rvalid_q;
  logic              misalign_q;

  logic [AWIDTH-1:0] widx;
  logic [OFFW-1:0]   off;
  logic [3:0]        off_ext;
  logic [3:0]        nbytes;
  logic              misaligned;
  logic              accept;
  logic              do_store;
  logic              do_load;
  logic [LANES-1:0]  lane_en;
  logic [DWIDTH-1:0] wdata;
  logic [DWIDTH-1:0] shifted;
  logic [DWIDTH-1:0] load_ext;
  logic              sign;

  assign widx       = bus.address[AWIDTH+OFFW-1:OFFW];
  assign off        = bus.address[OFFW-1:0];
  assign off_ext    = 4'(off);
  assign nbytes     = 4'd1 << bus.size;
  // Wider than a word, or offset not a multiple of the access size.
  assign misaligned = (nbytes > 4'(LANES)) || ((off_ext & (nbytes - 4'd1)) != 4'd0);
  assign accept     = bus.req && (state_q == S_RUN);
  assign do_store   = accept && bus.we && !misaligned;
  assign do_load    = accept && !bus.we && !misaligned;

  // Sweep control: walk the clear pointer once over every word, then run.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    if (state_q == S_CLEAR) begin
      if (!INIT_CLEAR) begin
        state_d = S_RUN;
      end else begin
        clr_we = 1'b1;
        if (ptr_q == '1) state_d = S_RUN;
        else             ptr_d   = ptr_q + 1'b1;
      end
    end
  end

  // Store lane enables and data, aligned to the byte offset inside the word.
  always_comb begin
    wdata = bus.data_in << {off, 3'b000};
    for (int l = 0; l < LANES; l++) begin
      lane_en[l] = (4'(l) >= off_ext) && (4'(l) < off_ext + nbytes);
    end
  end

  // Load path: shift the addressed lanes down, then sign/zero fill above the access.
  always_comb begin
    shifted = mem[widx] >> {off, 3'b000};
    case (bus.size)
      2'd0:    sign = shifted[7];
      2'd1:    sign = shifted[15];
      2'd2:    sign = shifted[31];
      default: sign = shifted[DWIDTH-1];
    endcase
    for (int l = 0; l < LANES; l++) begin
      load_ext[8*l +: 8] = (4'(l) < nbytes) ? shifted[8*l +: 8] : {8{bus.sext & sign}};
    end
  end

  // Memory array: clear-sweep writes and merged lane stores.
  // NOTE: the array has no reset term; its contents are zeroed by the sweep instead.
  always_ff @(posedge clk) begin
    if (clr_n && clr_we) begin
      mem[ptr_q] <= '0;
    end else if (clr_n && do_store) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_en[l]) mem[widx][8*l +: 8] <= wdata[8*l +: 8];
      end
    end
  end

  // State, sweep pointer and registered response pulses.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    if (!clr_n) begin
      state_q    <= S_CLEAR;
      ptr_q      <= '0;
      data_out_q <= '0;
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rvalid_q   <= do_load;
      misalign_q <= accept && misaligned;
      if (do_load) data_out_q <= load_ext;
    end
  end

  assign bus.ready    = (state_q == S_RUN);
  assign bus.data_out = data_out_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.misalign = misalign_q;
endmodule
